// File: rtl/clkgen_ctl.sv
// System-clock control block: turns PLL lock into a sequenced reset and
// generates runtime-programmable clock-enable strobes for slow peripherals.
module clkgen_ctl #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DIV_INIT    = 0,
    parameter int unsigned HOLD_CYC    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              locked_in,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [DIV_W-1:0]  div_val,
    output logic [NUM_CH-1:0] ce,
    output logic              rst_out,
    output logic              clk_ok,
    output logic              lock_lost,
    input  logic              lock_lost_clr
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;
    logic [HOLD_W-1:0]      hold_q;
    logic [HOLD_W-1:0]      hold_d;
    logic                   lost_set;

    // Lock synchroniser; locked_in comes straight from the PLL, unrelated to clk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
        end
    end

    assign lk = sync_q[SYNC_STAGES-1];

    // State register with registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= WAIT_LOCK;
            hold_q    <= '0;
            rst_out   <= 1'b1;
            clk_ok    <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rst_out   <= (state_d != RUN);
            clk_ok    <= (state_d == RUN);
            lock_lost <= lost_set | (lock_lost & ~lock_lost_clr);
        end
    end

    // Reset sequencing: any loss of lk outside WAIT_LOCK restarts the sequence
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        lost_set = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_CYC - 1);
                end
            end
            HOLD: begin
                if (!lk) begin
                    state_d = WAIT_LOCK;
                end else if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d  = WAIT_LOCK;
                    lost_set = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
    end

    // Per-channel divisor and phase counter; a write restarts the period
    for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] cnt_q;
        logic             wr_hit;

        assign wr_hit = div_wr && (div_sel == SEL_W'(i));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q <= DIV_W'(DIV_INIT);
                cnt_q <= '0;
            end else if (wr_hit) begin
                div_q <= div_val;
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                cnt_q <= (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end

        // clk_ok mirrors RUN and clears asynchronously, so ce drops with rst
        assign ce[i] = clk_ok && (cnt_q == div_q);
    end

endmodule
